cmip_pluse_delay_mc: RTL and testbench

- Multi-channel, runtime-programmable pulse delay generator; successor to the fixed single-channel pulse delay (compile-time delay and hold).
- Each channel detects rising edges on its input and emits a pulse of programmable width after a programmable delay.
- Up to DEPTH edges per channel may be in flight at once.
- Sits between trigger sources (encoder / laser sync) and ADC/acquisition gating logic in the 32-channel acquisition FPGA.

---
 rtl/cmip_pluse_pkg.sv | 20 ++
 rtl/cmip_pluse_delay_ch.sv | 95 +++++++++
 rtl/cmip_pluse_delay_mc.sv | 77 +++++++
 tb/tb_cmip_pluse_delay_mc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmip_pluse_pkg.sv
// Purpose : shared widths and sizing helpers for the multi-channel pulse delay.
// Latency : n/a (package only).
// Backpres: n/a (package only).
package cmip_pluse_pkg;

   localparam int DLY_W_DEF  = 8;
   localparam int HOLD_W_DEF = 8;

   // Timestamp is one bit wider than the delay field so a target never
   // sits more than half a wrap ahead; equality compares stay unambiguous.
   function automatic int ts_width(input int dly_w);
      return dly_w + 1;
   endfunction

   // Queue pointers carry one extra wrap bit to tell full from empty.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/cmip_pluse_delay_ch.sv
// Purpose : one channel: rise detect, target-timestamp queue, fire compare, hold counter, sticky ovf.
// Latency : o_pluse rises D+1 clocks after the edge that samples the rise.
// Backpres: none; a rise arriving on a full queue (without a same-cycle pop) is dropped and o_ovf set.
// Ports   : i_clk/i_rst clock and async reset; i_en/i_clr enable and sync flush; i_sig trigger;
//           i_ts shared timestamp; i_delay/i_hold programmed D and H; o_pluse/o_busy/o_ovf status.
module cmip_pluse_delay_ch
   import cmip_pluse_pkg::*;
#(
   parameter int DLY_W  = DLY_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic                    i_clr,
   input  logic                    i_sig,
   input  logic [DLY_W:0]          i_ts,
   input  logic [DLY_W-1:0]        i_delay,
   input  logic [HOLD_W-1:0]       i_hold,
   output logic                    o_pluse,
   output logic                    o_busy,
   output logic                    o_ovf
);

   localparam int TS_W  = ts_width(DLY_W);
   localparam int PTR_W = ptr_width(DEPTH);
   localparam int IDX_W = PTR_W - 1;

   logic              sig_d1;
   logic [TS_W-1:0]   q_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [HOLD_W-1:0] hold_cnt;

   logic              rise;
   logic              q_empty;
   logic              q_full;
   logic              fire;
   logic              push;
   logic              drop;
   logic [TS_W-1:0]   target;
   logic [HOLD_W-1:0] hold_ld;

   assign rise    = i_sig & ~sig_d1;
   assign q_empty = (wr_ptr == rd_ptr);
   assign q_full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                    (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
   assign fire    = ~q_empty && (q_mem[rd_ptr[IDX_W-1:0]] == i_ts);
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign push    = rise & i_en & (~q_full | fire);
   assign drop    = rise & i_en & q_full & ~fire;
   assign target  = i_ts + {1'b0, i_delay} + TS_W'(1);
   assign hold_ld = (i_hold == '0) ? HOLD_W'(1) : i_hold;
   assign o_busy  = ~q_empty | o_pluse;

   // Edge register survives i_clr so a level held across a flush is not re-seen as a rise.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sig_d1 <= 1'b0;
      else       sig_d1 <= i_sig;
   end

   always_ff @(posedge i_clk) begin
      if (push && !i_clr && !i_rst) q_mem[wr_ptr[IDX_W-1:0]] <= target;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         hold_cnt <= '0;
         o_pluse  <= 1'b0;
         o_ovf    <= 1'b0;
      end else if (i_clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         hold_cnt <= '0;
         o_pluse  <= 1'b0;
         o_ovf    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (fire) rd_ptr <= rd_ptr + PTR_W'(1);
         if (drop) o_ovf  <= 1'b1;
         // A fire during an active pulse just reloads: pulses merge with no gap.
         if (fire) begin
            hold_cnt <= hold_ld;
            o_pluse  <= 1'b1;
         end else begin
            o_pluse <= (hold_cnt > HOLD_W'(1));
            if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
         end
      end
   end

endmodule

// File: rtl/cmip_pluse_delay_mc.sv
// Purpose : multi-channel programmable pulse delay; shared timestamp, optional input sync, channel array.
// Latency : D+1 clocks from the sampling edge (D+3 with CMIP_PLUSE_INPUT_SYNC_EN defined).
// Backpres: none; per-channel queue of DEPTH entries, overflow drops the edge and sets sticky o_ovf.
// Ports   : i_clk, i_rst (async, active high), i_en, i_clr, i_sig[CH_NUM], i_delay/i_hold packed per
//           channel at [n*W +: W]; o_pluse, o_busy, o_ovf one bit per channel.
// Option  : CMIP_PLUSE_INPUT_SYNC_EN adds a 2-flop synchronizer on each i_sig bit.
module cmip_pluse_delay_mc
   import cmip_pluse_pkg::*;
#(
   parameter int CH_NUM = 4,
   parameter int DLY_W  = DLY_W_DEF,
   parameter int HOLD_W = HOLD_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_clr,
   input  logic [CH_NUM-1:0]        i_sig,
   input  logic [CH_NUM*DLY_W-1:0]  i_delay,
   input  logic [CH_NUM*HOLD_W-1:0] i_hold,
   output logic [CH_NUM-1:0]        o_pluse,
   output logic [CH_NUM-1:0]        o_busy,
   output logic [CH_NUM-1:0]        o_ovf
);

   localparam int TS_W = ts_width(DLY_W);

   logic [TS_W-1:0]   ts;
   logic [CH_NUM-1:0] sig_in;

   // Free-running; a flush must not disturb targets already computed against it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) ts <= '0;
      else       ts <= ts + TS_W'(1);
   end

`ifdef CMIP_PLUSE_INPUT_SYNC_EN
   logic [CH_NUM-1:0] sync_q1;
   logic [CH_NUM-1:0] sync_q2;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= i_sig;
         sync_q2 <= sync_q1;
      end
   end

   assign sig_in = sync_q2;
`else
   assign sig_in = i_sig;
`endif

   for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
      cmip_pluse_delay_ch #(
         .DLY_W  (DLY_W),
         .HOLD_W (HOLD_W),
         .DEPTH  (DEPTH)
      ) u_ch (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_en    (i_en),
         .i_clr   (i_clr),
         .i_sig   (sig_in[n]),
         .i_ts    (ts),
         .i_delay (i_delay[n*DLY_W +: DLY_W]),
         .i_hold  (i_hold[n*HOLD_W +: HOLD_W]),
         .o_pluse (o_pluse[n]),
         .o_busy  (o_busy[n]),
         .o_ovf   (o_ovf[n])
      );
   end

endmodule

// File: tb/tb_cmip_pluse_delay_mc.sv
// Purpose : directed bench for cmip_pluse_delay_mc with an expected-pulse scoreboard.
// Latency : expected pulse start = sampling edge + D + 1 (+2 with input sync), end = start + max(H,1).
// Backpres: n/a.
module tb_cmip_pluse_delay_mc;

   localparam int CH = 4;
`ifdef CMIP_PLUSE_INPUT_SYNC_EN
   localparam int L = 2;
`else
   localparam int L = 0;
`endif

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_en;
   logic          i_clr;
   logic [CH-1:0] i_sig;
   logic [CH*8-1:0] i_delay;
   logic [CH*8-1:0] i_hold;
   logic [CH-1:0] o_pluse;
   logic [CH-1:0] o_busy;
   logic [CH-1:0] o_ovf;

   cmip_pluse_delay_mc #(.CH_NUM(CH), .DLY_W(8), .HOLD_W(8), .DEPTH(4)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_clr   (i_clr),
      .i_sig   (i_sig),
      .i_delay (i_delay),
      .i_hold  (i_hold),
      .o_pluse (o_pluse),
      .o_busy  (o_busy),
      .o_ovf   (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;        // index of the most recent rising edge
   logic [8:0] ts_m;      // only used to place the wrap test near ts=500

   always @(posedge i_clk) cyc <= cyc + 1;
   always @(posedge i_clk or posedge i_rst)
      if (i_rst) ts_m <= '0;
      else       ts_m <= ts_m + 9'd1;

   // Scoreboard entry: pulse on channel ch first seen high after edge s, first seen low after edge e.
   typedef struct { int ch; int s; int e; } iv_t;
   iv_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic expect_iv(input int c, input int s, input int e);
      iv_t v;
      v.ch = c; v.s = s; v.e = e;
      exp_q.push_back(v);
   endtask

   task automatic got_pulse(input int c, input int s, input int e);
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++)
         if (idx < 0 && exp_q[i].ch == c) idx = i;
      chk($sformatf("pulse_expected_ch%0d_at%0d", c, s), 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
         chk($sformatf("pulse_start_ch%0d", c), s, exp_q[idx].s);
         chk($sformatf("pulse_end_ch%0d", c), e, exp_q[idx].e);
         exp_q.delete(idx);
      end
   endtask

   // Monitor: edge-detect o_pluse per channel and retire scoreboard entries.
   logic [CH-1:0] prev = '0;
   int st [CH];
   always @(negedge i_clk) begin
      for (int c = 0; c < CH; c++) begin
         if (o_pluse[c] && !prev[c]) st[c] = cyc;
         if (!o_pluse[c] && prev[c]) got_pulse(c, st[c], cyc);
      end
      prev = o_pluse;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic setcfg(input int c, input int d, input int h);
      i_delay[c*8 +: 8] = 8'(d);
      i_hold[c*8 +: 8]  = 8'(h);
   endtask

   // One-clock high on the masked inputs; e is the edge that samples it.
   task automatic rise(input logic [CH-1:0] m, output int e);
      @(negedge i_clk);
      i_sig = i_sig | m;
      e = cyc + 1;
      @(negedge i_clk);
      i_sig = i_sig & ~m;
   endtask

   initial begin
      int e, e1, e2, e3, s, r;
      int ev [5];

      i_rst = 1'b1; i_en = 1'b1; i_clr = 1'b0; i_sig = '0;
      i_delay = '0; i_hold = '0;
      idle(3);
      chk("reset_pluse", 32'(o_pluse), 32'd0);
      chk("reset_busy",  32'(o_busy),  32'd0);
      chk("reset_ovf",   32'(o_ovf),   32'd0);
      i_rst = 1'b0;
      idle(3);

      // Single edge, D=10 H=5; D reprogrammed afterwards must not move the queued pulse.
      setcfg(0, 10, 5);
      rise(4'b0001, e);
      expect_iv(0, e + L + 11, e + L + 16);
      idle(3);
      setcfg(0, 3, 5);
      idle(25);
      chk("single_busy_after", 32'(o_busy[0]), 32'd0);

      // Three in flight on ch1, 3 clocks apart.
      setcfg(1, 20, 2);
      rise(4'b0010, e1); idle(1);
      rise(4'b0010, e2); idle(1);
      rise(4'b0010, e3);
      expect_iv(1, e1 + L + 21, e1 + L + 23);
      expect_iv(1, e2 + L + 21, e2 + L + 23);
      expect_iv(1, e3 + L + 21, e3 + L + 23);
      idle(3);
      chk("multi_busy_mid", 32'(o_busy[1]), 32'd1);
      idle(35);
      chk("multi_busy_after", 32'(o_busy[1]), 32'd0);

      // Full queue with a same-edge pop: fifth rise lands on the first fire edge, no drop.
      setcfg(2, 7, 1);
      for (int i = 0; i < 5; i++) begin
         rise(4'b0100, ev[i]);
         expect_iv(2, ev[i] + L + 8, ev[i] + L + 9);
      end
      idle(3);
      chk("full_poppush_ovf", 32'(o_ovf[2]), 32'd0);
      idle(20);

      // Overflow: D=100, four accepted, fifth dropped.
      setcfg(2, 100, 1);
      for (int i = 0; i < 4; i++) begin
         rise(4'b0100, ev[i]);
         expect_iv(2, ev[i] + L + 101, ev[i] + L + 102);
      end
      idle(3);
      chk("ovf_before_fifth", 32'(o_ovf[2]), 32'd0);
      rise(4'b0100, e);
      idle(3);
      chk("ovf_set", 32'(o_ovf[2]), 32'd1);
      idle(110);
      chk("ovf_sticky", 32'(o_ovf[2]), 32'd1);
      chk("ovf_busy_drained", 32'(o_busy[2]), 32'd0);
      rise(4'b0100, e);
      idle(5);
      chk("clr_busy_before", 32'(o_busy[2]), 32'd1);
      @(negedge i_clk); i_clr = 1'b1;
      @(negedge i_clk); i_clr = 1'b0;
      chk("clr_ovf", 32'(o_ovf[2]), 32'd0);
      chk("clr_busy", 32'(o_busy[2]), 32'd0);

      // Wrap: D=255, H=0 issued around ts=500 of the 9-bit timestamp.
      setcfg(0, 255, 0);
      for (int k = 0; k < 1024 && ts_m != 9'd499; k++) @(negedge i_clk);
      rise(4'b0001, e);
      expect_iv(0, e + L + 256, e + L + 257);
      idle(270);

      // D=0: one clock after the sampling edge.
      setcfg(0, 0, 3);
      rise(4'b0001, e);
      expect_iv(0, e + L + 1, e + L + 4);
      idle(10);

      // Merge on ch3: second fire reloads the hold counter mid-pulse.
      setcfg(3, 5, 8);
      rise(4'b1000, e1); idle(1);
      rise(4'b1000, e2);
      expect_iv(3, e1 + L + 6, e2 + L + 14);
      idle(25);

      // Enable: queued entry still fires while i_en is low, the ignored rise never does.
      setcfg(1, 4, 2);
      rise(4'b0010, e);
      expect_iv(1, e + L + 5, e + L + 7);
      idle(3);
      i_en = 1'b0;
      rise(4'b0010, e1);
      idle(4);
      i_en = 1'b1;
      idle(20);
      chk("en_busy_after", 32'(o_busy[1]), 32'd0);

      // Async reset mid-pulse on ch0 while ch1 still has a far-off entry queued.
      setcfg(0, 3, 10);
      setcfg(1, 200, 1);
      rise(4'b0011, e);
      s = e + L + 4;
      while (cyc < s + 2) @(negedge i_clk);
      @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      r = cyc;
      expect_iv(0, s, r);
      #1;
      chk("rst_async_pluse", 32'(o_pluse[0]), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      idle(2);
      i_rst = 1'b0;
      idle(250);
      chk("rst_busy_after", 32'(o_busy), 32'd0);

      idle(5);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
